// File: rtl/sig_start_stop_timer_pkg.sv
// Shared types for the start/stop pause timer.
package sig_start_stop_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sig_start_stop_timer_tick_prescaler.sv
// Divides clk into one-cycle ticks every scale_q+1 clocks; held at zero while restart is high.
module tick_prescaler #(
  parameter int unsigned PRE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 sclr,
  input  logic                 restart,
  input  logic [PRE_WIDTH-1:0] scale_q,
  output logic                 tick
);

  logic [PRE_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (sclr || restart) begin
      cnt <= '0;
    end else if (cnt == scale_q) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRE_WIDTH'(1);
    end
  end

  assign tick = !restart && (cnt == scale_q);

endmodule

// File: rtl/sig_start_stop_timer.sv
// Holds pause high for (scale+1)*(length+1) clocks after every change of sig.
module sig_start_stop_timer
  import sig_start_stop_timer_pkg::*;
#(
  parameter int unsigned PRE_WIDTH = 16,
  parameter int unsigned WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 sclr,
  input  logic                 sig,
  input  logic [PRE_WIDTH-1:0] scale,
  input  logic [WIDTH-1:0]     length,
  output logic                 pause
);

  state_t               state;
  logic                 sig_d;
  logic                 sig_edge;
  logic                 tick;
  logic                 restart;
  logic [PRE_WIDTH-1:0] scale_q;
  logic [WIDTH-1:0]     length_q;
  logic [WIDTH-1:0]     tcnt;

  assign sig_edge = sig ^ sig_d;
  // Keeping the prescaler in restart while idle pins it at zero without a separate enable.
  assign restart  = sig_edge || (state == ST_IDLE);

  tick_prescaler #(
    .PRE_WIDTH(PRE_WIDTH)
  ) u_prescaler (
    .clk    (clk),
    .sclr   (sclr),
    .restart(restart),
    .scale_q(scale_q),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (sclr) begin
      state    <= ST_IDLE;
      pause    <= 1'b0;
      sig_d    <= 1'b0;
      scale_q  <= '0;
      length_q <= '0;
      tcnt     <= '0;
    end else begin
      sig_d <= sig;
      // An edge outranks the final tick so a retrigger never leaves a gap.
      if (sig_edge) begin
        state    <= ST_RUN;
        pause    <= 1'b1;
        scale_q  <= scale;
        length_q <= length;
        tcnt     <= '0;
      end else if (state == ST_RUN && tick) begin
        if (tcnt == length_q) begin
          state <= ST_IDLE;
          pause <= 1'b0;
          tcnt  <= '0;
        end else begin
          tcnt <= tcnt + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sig_start_stop_timer.sv
// Directed bench with a queue of expected pause values, one per clock.
module tb_sig_start_stop_timer;

  logic        clk = 1'b0;
  logic        sclr;
  logic        sig;
  logic [15:0] scale;
  logic [15:0] length;
  logic        pause;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  bit    exp_q[$];
  longint rem  = 0;
  bit     sigp = 1'b0;
  string  tag  = "reset";

  sig_start_stop_timer #(
    .PRE_WIDTH(16),
    .WIDTH    (16)
  ) dut (
    .clk   (clk),
    .sclr  (sclr),
    .sig   (sig),
    .scale (scale),
    .length(length),
    .pause (pause)
  );

  always #5 clk = ~clk;

  // Reference: a plain countdown of clocks remaining in the window.
  task automatic cyc(input int unsigned n);
    bit e;
    for (int unsigned i = 0; i < n; i++) begin
      if (sclr) begin
        rem  = 0;
        sigp = 1'b0;
      end else if (sig != sigp) begin
        rem  = (longint'(scale) + 1) * (longint'(length) + 1);
        sigp = sig;
      end
      exp_q.push_back(rem > 0);
      if (rem > 0) rem--;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      compared++;
      assert (pause === e) else begin
        mismatched++;
        $error("FAIL %s: pause=%0b expected %0b at %0t", tag, pause, e, $time);
      end
    end
  endtask

  initial begin
    sclr = 1'b1; sig = 1'b0; scale = 16'd0; length = 16'd0;
    @(posedge clk); #1;

    tag = "reset_hold";  cyc(10);
    sclr = 1'b0;
    tag = "idle";        cyc(1000);

    tag = "small_rise";  scale = 16'd2; length = 16'd3; sig = 1'b1; cyc(20);
    tag = "small_fall";  sig = 1'b0; cyc(20);

    // Retrigger at a scaled-down 10 ms setting (7200-clock window).
    tag = "retrig_rise"; scale = 16'd71; length = 16'd99; sig = 1'b1; cyc(100);
    tag = "retrig_fall"; sig = 1'b0; cyc(7300);

    tag = "full_rise";   sig = 1'b1; cyc(7210);
    tag = "full_fall";   sig = 1'b0; cyc(7300);

    tag = "min_pulse";   scale = 16'd0; length = 16'd0;
    sig = 1'b1; cyc(3);
    sig = 1'b0; cyc(3);
    tag = "min_toggle";
    for (int k = 0; k < 6; k++) begin
      sig = ~sig; cyc(1);
    end
    cyc(3);

    // Second edge around the final tick: before, on, and just after it.
    scale = 16'd1; length = 16'd2;
    for (int d = 5; d <= 7; d++) begin
      tag = $sformatf("final_tick_d%0d", d);
      sig = ~sig; cyc(d);
      sig = ~sig; cyc(10);
    end

    tag = "limits_change"; scale = 16'd3; length = 16'd4;
    sig = ~sig; cyc(5);
    scale = 16'd9; length = 16'd9; cyc(25);
    scale = 16'd3; length = 16'd4;

    tag = "reset_mid";     sig = ~sig; cyc(10);
    sclr = 1'b1; cyc(1);
    sclr = 1'b0; tag = "after_reset"; cyc(5);
    sig = ~sig; tag = "full_after_reset"; cyc(30);

    tag = "sig_high_at_release"; sclr = 1'b1; sig = 1'b1; cyc(2);
    sclr = 1'b0; cyc(30);

    tag = "max_limits"; scale = 16'hFFFF; length = 16'd0;
    sig = ~sig; cyc(200);
    sclr = 1'b1; cyc(1);
    sclr = 1'b0; scale = 16'd0; length = 16'hFFFF; sig = ~sig; cyc(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
